sipo_packer: RTL and testbench

Serial-in/parallel-out packer for the DRAM spectrometer datapath. It gathers narrow spectrometer output words, one per valid cycle, into wide words and writes them into the FIFO that the downstream `piso` drains toward DRAM. Chunk order is chosen so that `piso` emits chunks in the same order they arrived. It also reports FIFO overflow and, optionally, aligns packing to spectrum boundaries.

---
 rtl/sipo_packer.sv | 109 ++++++++++
 tb/tb_sipo_packer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/sipo_packer.sv
// rtl/sipo_packer.sv - packs INPUT_SIZE chunks into OUTPUT_SIZE FIFO words, first chunk in the MSBs.
// Optional spectrum alignment: SYNC_ALIGN_EN.
module sipo_packer #(
  parameter int INPUT_SIZE  = 128,
  parameter int OUTPUT_SIZE = 512
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic [INPUT_SIZE-1:0]  i_data,
  input  logic                   i_valid,
  input  logic                   i_sync,
  input  logic                   fifo_full,
  output logic [OUTPUT_SIZE-1:0] o_parallel,
  output logic                   fifo_we,
  output logic                   overflow,
  output logic [15:0]            drop_count
);

  localparam int CYCLES_BTW = OUTPUT_SIZE / INPUT_SIZE;
  localparam int IDX_W      = (CYCLES_BTW > 2) ? $clog2(CYCLES_BTW) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CYCLES_BTW - 1);

  logic [OUTPUT_SIZE-1:0] buf_q, buf_d;
  logic [OUTPUT_SIZE-1:0] o_parallel_q, o_parallel_d;
  logic [IDX_W-1:0]       idx_q, idx_d, eff_idx;
  logic                   fifo_we_q, fifo_we_d;
  logic                   overflow_q, overflow_d;
  logic [15:0]            drop_count_q, drop_count_d;
  logic                   accept;

`ifdef SYNC_ALIGN_EN
  typedef enum logic {WAIT_SYNC = 1'b0, PACK = 1'b1} state_t;
  state_t state_q, state_d;

  // A sync chunk always restarts the word, which also covers leaving WAIT_SYNC.
  assign accept  = ce && i_valid && ((state_q == PACK) || i_sync);
  assign eff_idx = i_sync ? '0 : idx_q;

  always_comb begin
    state_d = state_q;
    if (accept) state_d = PACK;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= WAIT_SYNC;
    else     state_q <= state_d;
  end
`else
  logic unused_sync;
  assign unused_sync = i_sync;
  assign accept      = ce && i_valid;
  assign eff_idx     = idx_q;
`endif

  always_comb begin
    buf_d        = buf_q;
    idx_d        = idx_q;
    o_parallel_d = o_parallel_q;
    fifo_we_d    = fifo_we_q;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    if (ce) begin
      fifo_we_d = 1'b0;
      if (accept) begin
        for (int k = 0; k < CYCLES_BTW; k++) begin
          if (eff_idx == IDX_W'(k)) buf_d[OUTPUT_SIZE-1-k*INPUT_SIZE -: INPUT_SIZE] = i_data;
        end
        if (eff_idx == LAST_IDX) begin
          idx_d = '0;
          if (!fifo_full) begin
            o_parallel_d = buf_d;
            fifo_we_d    = 1'b1;
          end else begin
            overflow_d = 1'b1;
            if (drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
          end
        end else begin
          idx_d = eff_idx + IDX_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q        <= '0;
      idx_q        <= '0;
      o_parallel_q <= '0;
      fifo_we_q    <= 1'b0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      buf_q        <= buf_d;
      idx_q        <= idx_d;
      o_parallel_q <= o_parallel_d;
      fifo_we_q    <= fifo_we_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  // A strobe pending across ce=0 cycles is only presented while ce is high.
  assign fifo_we    = fifo_we_q && ce;
  assign o_parallel = o_parallel_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_sipo_packer.sv
// tb/tb_sipo_packer.sv - self-checking bench for sipo_packer with a queue-based reference model.
module tb_sipo_packer;
  logic         clk, rst, ce, i_valid, i_sync, fifo_full;
  logic [127:0] i_data;
  logic [511:0] o_parallel;
  logic         fifo_we, overflow;
  logic [15:0]  drop_count;

  int errors = 0;
  int checks = 0;

  logic [127:0] mq[$];
  logic         m_pending, m_ovf, m_synced;
  logic [511:0] m_par;
  logic [15:0]  m_drop;

  sipo_packer dut (
    .clk(clk), .rst(rst), .ce(ce), .i_data(i_data), .i_valid(i_valid), .i_sync(i_sync),
    .fifo_full(fifo_full), .o_parallel(o_parallel), .fifo_we(fifo_we),
    .overflow(overflow), .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pending = 1'b0;
    m_par     = '0;
    m_ovf     = 1'b0;
    m_drop    = '0;
`ifdef SYNC_ALIGN_EN
    m_synced  = 1'b0;
`else
    m_synced  = 1'b1;
`endif
  endtask

  task automatic model_step(input logic r, input logic c, input logic v, input logic s,
                            input logic f, input logic [127:0] d);
    if (r) begin
      model_reset();
    end else if (c) begin
      m_pending = 1'b0;
`ifdef SYNC_ALIGN_EN
      if (v && s) begin
        mq.delete();
        m_synced = 1'b1;
      end
`endif
      if (v && m_synced) begin
        mq.push_back(d);
        if (mq.size() == 4) begin
          if (!f) begin
            m_par     = {mq[0], mq[1], mq[2], mq[3]};
            m_pending = 1'b1;
          end else begin
            m_ovf = 1'b1;
            if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
          end
          mq.delete();
        end
      end
    end
  endtask

  task automatic cyc(input logic r, input logic c, input logic v, input logic s,
                     input logic f, input logic [127:0] d);
    rst = r; ce = c; i_valid = v; i_sync = s; fifo_full = f; i_data = d;
    #1;
    chk("fifo_we", 512'(fifo_we), 512'(m_pending && c));
    chk("o_parallel", o_parallel, m_par);
    chk("overflow", 512'(overflow), 512'(m_ovf));
    chk("drop_count", 512'(drop_count), 512'(m_drop));
    @(posedge clk);
    model_step(r, c, v, s, f, d);
    #1;
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic chunk(input int k, input logic s, input logic f);
    cyc(1'b0, 1'b1, 1'b1, s, f, 128'(k));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; i_valid = 1'b0; i_sync = 1'b0; fifo_full = 1'b0; i_data = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("reset_o_parallel", o_parallel, '0);
    chk("reset_fifo_we", 512'(fifo_we), '0);
    chk("reset_drop_count", 512'(drop_count), '0);

    // full-rate packing
    for (int k = 1; k <= 4; k++) chunk(k, k == 1, 1'b0);
    chk("word1_layout", o_parallel, {128'd1, 128'd2, 128'd3, 128'd4});
    chk("word1_latency", 512'(fifo_we), 512'(1));
    for (int k = 5; k <= 8; k++) chunk(k, k == 5, 1'b0);
    idle(2);

    // bubbles
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      chunk(k, k == 1 || k == 5, 1'b0);
      idle(1);
    end
    idle(1);

    // overflow
    do_reset();
    for (int k = 1; k <= 8; k++) chunk(k, k == 1 || k == 5, k == 4);
    chk("ovf_word2", o_parallel, {128'd5, 128'd6, 128'd7, 128'd8});
    chk("ovf_drop_count", 512'(drop_count), 512'(1));
    chk("ovf_flag", 512'(overflow), 512'(1));
    idle(2);

`ifdef SYNC_ALIGN_EN
    // sync realign
    do_reset();
    chunk(20, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) chunk(k, k == 1, 1'b0);
    for (int k = 9; k <= 12; k++) chunk(k, k == 9, 1'b0);
    chk("realign_word", o_parallel, {128'd9, 128'd10, 128'd11, 128'd12});
    chk("realign_we", 512'(fifo_we), 512'(1));
    chk("realign_no_drop", 512'(drop_count), '0);
    idle(2);
`endif

    // reset mid-word
    do_reset();
    chunk(1, 1'b1, 1'b0);
    chunk(2, 1'b0, 1'b0);
    do_reset();
    chk("rst_we_zero", 512'(fifo_we), '0);
    for (int k = 5; k <= 8; k++) chunk(k, k == 5, 1'b0);
    chk("rst_word", o_parallel, {128'd5, 128'd6, 128'd7, 128'd8});
    idle(2);

    // clock enable hold
    do_reset();
    for (int k = 1; k <= 4; k++) chunk(k, k == 1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 128'd99);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    idle(3);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom % 60) == 0, ($urandom % 8) != 0, ($urandom % 4) != 0,
          ($urandom % 6) == 0, ($urandom % 5) == 0,
          {$urandom, $urandom, $urandom, $urandom});
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
